// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU divider.
package alu_pkg;

   localparam int unsigned DIV_MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   // Quotient returned on divide-by-zero; sliced down to the operand width.
   localparam logic [DIV_MAX_WIDTH-1:0] DBZ_QUOTIENT = {DIV_MAX_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {A,Q} against divisor D.
// Kept separate so unrolled or higher-radix variants can chain it.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   a_sh;
   logic [WIDTH+1:0] trial;
   logic             unused_trial_bit;

   // The shifted accumulator can reach 2*D-1, so the subtract needs two guard bits.
   always_comb begin
      a_sh  = {a_in, q_in[WIDTH-1]};
      trial = {1'b0, a_sh} - {2'b00, d_in};
      if (!trial[WIDTH+1]) begin
         a_out = trial[WIDTH-1:0];
         q_out = {q_in[WIDTH-2:0], 1'b1};
      end else begin
         a_out = a_sh[WIDTH-1:0];
         q_out = {q_in[WIDTH-2:0], 1'b0};
      end
   end

   // A successful trial is always below D, so this bit carries no information.
   assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/alu_div_seq.sv
// Sequential restoring divider: one shift/subtract step per clock, signed or unsigned.
// Produces {remainder, quotient} with a start/busy/done handshake.
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] result,
   output div_state_e         dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e         state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_out_q, dbz_out_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]   step_quo;
   logic [WIDTH-1:0]   rem_fixed;
   logic [WIDTH-1:0]   quo_fixed;

   div_step #(.WIDTH(WIDTH)) u_step (
      .a_in  (acc_q),
      .q_in  (quo_q),
      .d_in  (dvs_q),
      .a_out (step_acc),
      .q_out (step_quo)
   );

   // Handshake: start is honoured only in IDLE (including the done cycle) and is
   // never queued; busy spans the accepted operation through FIX; done is a
   // one-cycle pulse, and result/div_by_zero change only on the edge raising it.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      dbz_out_d = dbz_out_q;
      result_d  = result_q;

      a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
      b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
      rem_fixed = r_neg_q ? -acc_q : acc_q;
      quo_fixed = q_neg_q ? -quo_q : quo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (b == '0) begin
                  // Remainder is the untouched dividend and the quotient all ones.
                  acc_d   = a;
                  quo_d   = DBZ_QUOTIENT[WIDTH-1:0];
                  dvs_d   = '0;
                  cnt_d   = '0;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  dbz_d   = 1'b1;
                  state_d = FIX;
               end else begin
                  acc_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  q_neg_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_d = signed_op & a[WIDTH-1];
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            result_d  = {rem_fixed, quo_fixed};
            dbz_out_d = dbz_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
         result_q  <= result_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign result      = result_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: 32-bit directed/random cases and an 8-bit sweep against
// an arithmetic reference model, plus protocol and reset scenarios.
module tb_alu_div_seq;

   localparam int SB_W = 17;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        s32_start  = 1'b0;
   logic        s32_signed = 1'b0;
   logic [31:0] s32_a      = '0;
   logic [31:0] s32_b      = '0;
   logic        s32_busy, s32_done, s32_dbz;
   logic [63:0] s32_res;
   logic [1:0]  s32_state;

   logic        s8_start  = 1'b0;
   logic        s8_signed = 1'b0;
   logic [7:0]  s8_a      = '0;
   logic [7:0]  s8_b      = '0;
   logic        s8_busy, s8_done, s8_dbz;
   logic [15:0] s8_res;
   logic [1:0]  s8_state;

   int total = 0;
   int bad   = 0;
   logic [SB_W-1:0] exp_q[$];

   alu_div_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(s32_start), .signed_op(s32_signed),
      .a(s32_a), .b(s32_b), .busy(s32_busy), .done(s32_done),
      .div_by_zero(s32_dbz), .result(s32_res), .dbg_state(s32_state)
   );

   alu_div_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(s8_start), .signed_op(s8_signed),
      .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done),
      .div_by_zero(s8_dbz), .result(s8_res), .dbg_state(s8_state)
   );

   // ---------------- reference model ----------------
   // Truncating division: remainder follows the dividend; b==0 gives all-ones / a.
   function automatic void ref_div(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input bit s, output logic [63:0] q, output logic [63:0] r,
                                   output logic dz);
      logic [63:0] mask, av, bv;
      longint sa, sb;
      mask = (64'd1 << w) - 64'd1;
      av   = a_in & mask;
      bv   = b_in & mask;
      dz   = (bv == 64'd0);
      if (dz) begin
         q = mask;
         r = av;
      end else begin
         if (s) begin
            sa = $signed(av << (64 - w)) >>> (64 - w);
            sb = $signed(bv << (64 - w)) >>> (64 - w);
         end else begin
            sa = longint'(av);
            sb = longint'(bv);
         end
         q = 64'(sa / sb) & mask;
         r = 64'(sa % sb) & mask;
      end
   endfunction

   // ---------------- drivers ----------------
   // Called at a negedge with the DUT idle or in its done cycle; returns in the done cycle.
   task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [63:0] res, output logic dbz, output int lat, output int busy_n);
      s32_a = a; s32_b = b; s32_signed = s; s32_start = 1'b1;
      @(negedge clk);
      s32_start = 1'b0; s32_a = $urandom; s32_b = $urandom; s32_signed = 1'($urandom_range(0, 1));
      lat = 0; busy_n = 0;
      while (lat < 100 && s32_done !== 1'b1) begin
         if (s32_busy === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      res = s32_res;
      dbz = s32_dbz;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s);
      logic [63:0] q, r;
      logic dz;
      logic [SB_W-1:0] exp_v;
      int lat, sa, sb, sq, sr;
      bit ok;
      ref_div(8, {56'd0, a}, {56'd0, b}, s, q, r, dz);
      exp_q.push_back({dz, r[7:0], q[7:0]});
      s8_a = a; s8_b = b; s8_signed = s; s8_start = 1'b1;
      @(negedge clk);
      s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_signed = ~s;
      lat = 0;
      while (lat < 40 && s8_done !== 1'b1) begin
         @(negedge clk);
         lat++;
      end
      exp_v = exp_q.pop_front();
      total++;
      if ({s8_dbz, s8_res} !== exp_v) begin
         bad++;
         $display("FAIL sweep8_result a=%h b=%h s=%0d: got dbz=%b res=%h, expected dbz=%b res=%h",
                  a, b, s, s8_dbz, s8_res, exp_v[16], exp_v[15:0]);
      end
      total++;
      if (lat != ((b == 8'd0) ? 1 : 9)) begin
         bad++;
         $display("FAIL sweep8_latency a=%h b=%h: got %0d cycles, expected %0d", a, b, lat,
                  (b == 8'd0) ? 1 : 9);
      end
      if (b != 8'd0) begin
         if (s) begin
            sa = int'($signed(a)); sb = int'($signed(b));
            sq = int'($signed(s8_res[7:0])); sr = int'($signed(s8_res[15:8]));
         end else begin
            sa = int'(a); sb = int'(b); sq = int'(s8_res[7:0]); sr = int'(s8_res[15:8]);
         end
         ok = (((sq * sb + sr) & 255) == int'(a)) &&
              (((sr < 0) ? -sr : sr) < ((sb < 0) ? -sb : sb)) &&
              ((sr == 0) || ((sr < 0) == (sa < 0)));
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL sweep8_props a=%0d b=%0d s=%0d: got q=%0d r=%0d, expected q*b+r==a, |r|<|b|, sign(r)==sign(a)",
                     sa, sb, s, sq, sr);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({s32_busy, s32_done, s32_dbz} !== 3'b000 || s32_res !== 64'd0) begin
         bad++;
         $display("FAIL reset32: got busy=%b done=%b dbz=%b res=%h, expected all 0",
                  s32_busy, s32_done, s32_dbz, s32_res);
      end
      total++;
      if ({s8_busy, s8_done, s8_dbz} !== 3'b000 || s8_res !== 16'd0) begin
         bad++;
         $display("FAIL reset8: got busy=%b done=%b dbz=%b res=%h, expected all 0",
                  s8_busy, s8_done, s8_dbz, s8_res);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic();
      logic [63:0] res;
      logic dbz;
      int lat, bn;
      op32(32'd100, 32'd7, 1'b0, res, dbz, lat, bn);
      total++;
      if (res !== {32'd2, 32'd14}) begin
         bad++; $display("FAIL u32_result: got %h, expected %h", res, {32'd2, 32'd14});
      end
      total++;
      if (dbz !== 1'b0) begin bad++; $display("FAIL u32_dbz: got %b, expected 0", dbz); end
      total++;
      if (lat != 33) begin bad++; $display("FAIL u32_latency: got %0d, expected 33", lat); end
      total++;
      if (bn != 33) begin bad++; $display("FAIL u32_busy_cycles: got %0d, expected 33", bn); end
      @(negedge clk);
      total++;
      if (s32_done !== 1'b0 || s32_busy !== 1'b0) begin
         bad++; $display("FAIL u32_done_pulse: got done=%b busy=%b, expected 0 0", s32_done, s32_busy);
      end
      total++;
      if (s32_res !== {32'd2, 32'd14}) begin
         bad++; $display("FAIL u32_result_hold: got %h, expected %h", s32_res, {32'd2, 32'd14});
      end
   endtask

   task automatic test_signed_basic();
      logic [31:0] ta [0:3];
      logic [31:0] tb [0:3];
      logic [63:0] te [0:3];
      bit          ts [0:3];
      logic [63:0] res;
      logic dbz;
      int lat, bn;
      ta[0] = 32'hFFFFFF9C; tb[0] = 32'd7;        te[0] = {32'hFFFFFFFE, 32'hFFFFFFF2}; ts[0] = 1'b1;
      ta[1] = 32'd100;      tb[1] = 32'hFFFFFFF9; te[1] = {32'd2, 32'hFFFFFFF2};        ts[1] = 1'b1;
      ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF; te[2] = {32'd0, 32'h80000000};        ts[2] = 1'b1;
      ta[3] = 32'h80000000; tb[3] = 32'hFFFFFFFF; te[3] = {32'h80000000, 32'd0};        ts[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         op32(ta[i], tb[i], ts[i], res, dbz, lat, bn);
         total++;
         if (res !== te[i] || dbz !== 1'b0) begin
            bad++;
            $display("FAIL s32_case%0d: got res=%h dbz=%b, expected res=%h dbz=0", i, res, dbz, te[i]);
         end
         total++;
         if (lat != 33) begin bad++; $display("FAIL s32_latency%0d: got %0d, expected 33", i, lat); end
      end
   endtask

   task automatic test_div_by_zero();
      logic [31:0] ta [0:2];
      bit          ts [0:2];
      logic [63:0] res;
      logic dbz;
      int lat, bn;
      ta[0] = 32'h00001234; ts[0] = 1'b0;
      ta[1] = 32'h00001234; ts[1] = 1'b1;
      ta[2] = 32'hFFFFFF00; ts[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op32(ta[i], 32'd0, ts[i], res, dbz, lat, bn);
         total++;
         if (res !== {ta[i], 32'hFFFFFFFF} || dbz !== 1'b1) begin
            bad++;
            $display("FAIL dbz_case%0d: got res=%h dbz=%b, expected res=%h dbz=1",
                     i, res, dbz, {ta[i], 32'hFFFFFFFF});
         end
         total++;
         if (lat != 1 || bn != 1) begin
            bad++;
            $display("FAIL dbz_timing%0d: got latency=%0d busy=%0d, expected 1 1", i, lat, bn);
         end
      end
   endtask

   task automatic test_random32();
      logic [31:0] a, b;
      logic [63:0] res, q, r;
      logic dbz, dz;
      bit s;
      int lat, bn;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
         if (b == 32'd0 && $urandom_range(0, 1) == 0) b = 32'd1;
         s = 1'($urandom_range(0, 1));
         ref_div(32, {32'd0, a}, {32'd0, b}, s, q, r, dz);
         op32(a, b, s, res, dbz, lat, bn);
         total++;
         if (res !== {r[31:0], q[31:0]} || dbz !== dz) begin
            bad++;
            $display("FAIL rand32 a=%h b=%h s=%0d: got res=%h dbz=%b, expected res=%h dbz=%b",
                     a, b, s, res, dbz, {r[31:0], q[31:0]}, dz);
         end
         total++;
         if (lat != ((b == 32'd0) ? 1 : 33)) begin
            bad++; $display("FAIL rand32_latency a=%h b=%h: got %0d", a, b, lat);
         end
      end
   endtask

   task automatic test_sweep8();
      logic [7:0] cb [0:4] = '{8'h01, 8'h03, 8'h7F, 8'h80, 8'hFF};
      logic [7:0] a, b;
      for (int sm = 0; sm < 2; sm++)
         for (int bi = 0; bi < 5; bi++)
            for (int ai = 0; ai < 256; ai++)
               op8(8'(ai), cb[bi], sm[0]);
      for (int i = 0; i < 600; i++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         op8(a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL sweep8_queue: got %0d entries left, expected 0", exp_q.size());
      end
   endtask

   task automatic test_start_mid_run();
      logic [63:0] res;
      logic dbz;
      int lat, bn, k;
      bit seen_early;
      op32(32'd77, 32'd5, 1'b0, res, dbz, lat, bn);
      @(negedge clk);
      s32_a = 32'd1000; s32_b = 32'd3; s32_signed = 1'b0; s32_start = 1'b1;
      @(negedge clk);
      s32_start = 1'b0;
      k = 0; seen_early = 1'b0;
      while (k < 100 && s32_done !== 1'b1) begin
         if (k == 5) begin s32_a = 32'd5; s32_b = 32'd1; s32_start = 1'b1; end
         if (k == 6) s32_start = 1'b0;
         if (k == 10 && s32_res !== {32'd2, 32'd15}) seen_early = 1'b1;
         @(negedge clk);
         k++;
      end
      total++;
      if (seen_early) begin bad++; $display("FAIL midrun_hold: result changed during run, expected %h", {32'd2, 32'd15}); end
      total++;
      if (k != 33 || s32_res !== {32'd1, 32'd333}) begin
         bad++;
         $display("FAIL midrun_result: got latency=%0d res=%h, expected 33 %h", k, s32_res, {32'd1, 32'd333});
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (s32_busy !== 1'b0 || s32_done !== 1'b0) begin
            bad++; $display("FAIL midrun_not_queued: got busy=%b done=%b, expected 0 0", s32_busy, s32_done);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] res, q, r;
      logic dbz, dz;
      int lat, bn;
      bit got_done;
      s32_a = 32'hDEADBEEF; s32_b = 32'h00001234; s32_signed = 1'b0; s32_start = 1'b1;
      @(negedge clk);
      s32_start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({s32_busy, s32_done, s32_dbz} !== 3'b000 || s32_res !== 64'd0) begin
         bad++;
         $display("FAIL reset_mid_op: got busy=%b done=%b dbz=%b res=%h, expected all 0",
                  s32_busy, s32_done, s32_dbz, s32_res);
      end
      got_done = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (s32_done !== 1'b0 || s32_busy !== 1'b0) got_done = 1'b1;
      end
      total++;
      if (got_done) begin bad++; $display("FAIL reset_no_done: got done/busy activity under reset, expected none"); end
      reset_n = 1'b1;
      @(negedge clk);
      ref_div(32, 64'hFFFFFFF0, 64'd9, 1'b1, q, r, dz);
      op32(32'hFFFFFFF0, 32'd9, 1'b1, res, dbz, lat, bn);
      total++;
      if (res !== {r[31:0], q[31:0]} || dbz !== dz || lat != 33) begin
         bad++;
         $display("FAIL reset_fresh_op: got res=%h dbz=%b latency=%0d, expected res=%h dbz=%b latency=33",
                  res, dbz, lat, {r[31:0], q[31:0]}, dz);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed_basic();
      test_div_by_zero();
      test_random32();
      test_sweep8();
      test_start_mid_run();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
